// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR datapath (tap chain and output stage).
package fir_pkg;
  localparam int SUM_W      = 24;
  localparam int OUT_W      = 8;
  localparam int COEF_W     = 16;
  localparam int SAMPLE_W   = 8;
  localparam int FRAC_SHIFT = 15;

  typedef logic signed [SUM_W-1:0]    sum_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Event counter that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction
endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO; the head is read straight from storage flops, so rdata
// and empty never depend combinationally on pop.
module fir_out_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    // A full FIFO still takes a write when the head leaves the same cycle.
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/fir_output_stage.sv
// Tail of the transposed FIR: decimate, round/saturate the tap-chain sum to the
// sample domain, and queue results for a valid/ready consumer without stalling.
module fir_output_stage #(
  parameter int SUM_W      = fir_pkg::SUM_W,
  parameter int OUT_W      = fir_pkg::OUT_W,
  parameter int FRAC_SHIFT = fir_pkg::FRAC_SHIFT,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [SUM_W-1:0] sum_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      sat_count,
  output logic [15:0]      drop_count
);
  import fir_pkg::*;

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH+1);
  localparam logic signed [SUM_W:0] RND  = (SUM_W+1)'(2**(FRAC_SHIFT-1));
  localparam logic signed [SUM_W:0] MAXV = (SUM_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [SUM_W:0] MINV = (SUM_W+1)'(-(2**(OUT_W-1)));

  logic [PH_W-1:0]   phase_q, phase_d;
  logic              v1_q, v1_d, v2_q, v2_d, sat2_q, sat2_d;
  logic [SUM_W-1:0]  s1_q, s1_d;
  logic [OUT_W-1:0]  q2_q, q2_d;
  logic [15:0]       sat_count_q, sat_count_d, drop_count_q, drop_count_d;
  logic signed [SUM_W:0] sum_ext, t;
  logic              sat_hi, sat_lo, pop, drop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  always_comb begin
    phase_d = phase_q;
    if (sample_en) phase_d = (phase_q == PH_W'(DECIM-1)) ? '0 : phase_q + PH_W'(1);
    v1_d = sample_en && (phase_q == '0);
    s1_d = v1_d ? sum_in : s1_q;

    // One guard bit so adding the rounding constant cannot overflow.
    sum_ext = $signed({s1_q[SUM_W-1], s1_q});
    t       = (sum_ext + RND) >>> FRAC_SHIFT;
    sat_hi  = (t > MAXV);
    sat_lo  = (t < MINV);
    v2_d    = v1_q;
    sat2_d  = v1_q && (sat_hi || sat_lo);
    q2_d    = sat_hi ? MAXV[OUT_W-1:0] : sat_lo ? MINV[OUT_W-1:0] : t[OUT_W-1:0];

    pop          = out_valid && out_ready;
    drop         = v2_q && fifo_full && !pop;
    sat_count_d  = (v2_q && sat2_q) ? sat_inc(sat_count_q) : sat_count_q;
    drop_count_d = drop ? sat_inc(drop_count_q) : drop_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= '0;
      v1_q         <= 1'b0;
      s1_q         <= '0;
      v2_q         <= 1'b0;
      sat2_q       <= 1'b0;
      q2_q         <= '0;
      sat_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      phase_q      <= phase_d;
      v1_q         <= v1_d;
      s1_q         <= s1_d;
      v2_q         <= v2_d;
      sat2_q       <= sat2_d;
      q2_q         <= q2_d;
      sat_count_q  <= sat_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  fir_out_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (v2_q),
    .pop   (pop),
    .wdata (q2_q),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid  = !fifo_empty;
  assign sat_count  = sat_count_q;
  assign drop_count = drop_count_q;

  a_full_count: assert property (@(posedge clk) disable iff (reset)
    fifo_full == (fifo_count == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_fir_output_stage.sv
// Randomized and directed checks of fir_output_stage (DECIM=1 and DECIM=2)
// against a queue-based reference model with a scoreboard monitor.
module tb_fir_output_stage;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        se [2];
  int          si [2];
  logic        rdy [2];
  logic [7:0]  od [2];
  logic        ov [2];
  logic [15:0] sc_o [2];
  logic [15:0] dc_o [2];

  int errors = 0;
  int checks = 0;

  fir_output_stage #(.DECIM(1), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .reset(reset), .sample_en(se[0]), .sum_in(si[0][23:0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
    .sat_count(sc_o[0]), .drop_count(dc_o[0]));

  fir_output_stage #(.DECIM(2), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .reset(reset), .sample_en(se[1]), .sum_in(si[1][23:0]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
    .sat_count(sc_o[1]), .drop_count(dc_o[1]));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference quantizer: floor((s + 0.5 LSB) / 2^15), then clamp to int8.
  function automatic void quant(input int s, output int q, output bit sat);
    int t, f;
    t = s + 16384;
    if (t >= 0) f = t / 32768;
    else        f = -((-t + 32767) / 32768);
    q = f; sat = 1'b0;
    if (f > 127)  begin q = 127;  sat = 1'b1; end
    if (f < -128) begin q = -128; sat = 1'b1; end
  endfunction

  // Reference model state: results in flight, FIFO occupancy, accepted outputs.
  int occ [2];
  int ph [2];
  bit m_v1 [2], m_v2 [2], m_s1 [2], m_s2 [2];
  int m_q1 [2], m_q2 [2];
  int m_sat [2], m_drop [2];
  int sbq [2][$];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        occ[k] = 0; ph[k] = 0; m_v1[k] = 0; m_v2[k] = 0;
        m_sat[k] = 0; m_drop[k] = 0; sbq[k].delete();
      end else begin
        bit pop_m;
        pop_m = (occ[k] > 0) && rdy[k];
        if (m_v2[k]) begin
          if (m_s2[k] && m_sat[k] < 65535) m_sat[k]++;
          if (occ[k] < DEPTH || pop_m) begin
            sbq[k].push_back(m_q2[k]);
            occ[k]++;
          end else if (m_drop[k] < 65535) m_drop[k]++;
        end
        if (pop_m) occ[k]--;
        m_v2[k] = m_v1[k]; m_q2[k] = m_q1[k]; m_s2[k] = m_s1[k];
        m_v1[k] = se[k] && (ph[k] == 0);
        if (m_v1[k]) quant(si[k], m_q1[k], m_s1[k]);
        if (se[k]) ph[k] = (ph[k] + 1) % (k == 0 ? 1 : 2);
      end
    end
  end

  // Scoreboard monitor: every handshake pops one expected sample.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("valid%0d", k), ov[k], occ[k] > 0);
        if (ov[k] && rdy[k]) begin
          if (sbq[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected%0d: got %0d expected none", k, $signed(od[k]));
          end else chk($sformatf("data%0d", k), longint'($signed(od[k])), sbq[k].pop_front());
        end
        chk($sformatf("sat%0d", k), sc_o[k], m_sat[k]);
        chk($sformatf("drop%0d", k), dc_o[k], m_drop[k]);
      end
    end
  end

  task automatic cyc(input int k, input bit en, input int v, input bit r);
    se[k] = en; si[k] = v; rdy[k] = r;
    @(posedge clk); #1;
    se[k] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  int rv [6] = '{163840, 16384, -16384, -16385, 8388607, -8388608};
  int re [6] = '{5, 1, 0, -1, 127, -128};

  initial begin
    int got [$];
    for (int k = 0; k < 2; k++) begin se[k] = 0; si[k] = 0; rdy[k] = 0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ov[0], 0);
    chk("rst_data", od[0], 0);
    chk("rst_sat", sc_o[0], 0);
    chk("rst_drop", dc_o[0], 0);
    reset = 1'b0;

    // Rounding, saturation and 3-edge latency.
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, rv[i], 1);
      cyc(0, 0, 0, 1);
      chk("lat_early", ov[0], 0);
      cyc(0, 0, 0, 1);
      chk("lat_valid", ov[0], 1);
      chk($sformatf("round_%0d", rv[i]), longint'($signed(od[0])), re[i]);
      cyc(0, 0, 0, 1);
    end
    chk("sat_total", sc_o[0], 2);
    chk("sat_nodrop", dc_o[0], 0);

    // Decimation by 2 keeps the 1st and 3rd sums.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(1, i < 4, (i + 1) * 32768, 1);
      if (ov[1]) got.push_back($signed(od[1]));
    end
    chk("decim_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("decim_0", got[0], 1);
      chk("decim_1", got[1], 3);
    end
    rdy[1] = 0;

    // Backpressure: 6 into a 4-deep FIFO.
    do_reset();
    for (int i = 1; i <= 6; i++) cyc(0, 1, i * 32768, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("bp_drop", dc_o[0], 2);
    for (int i = 1; i <= 4; i++) begin
      chk("bp_valid", ov[0], 1);
      chk("bp_data", longint'($signed(od[0])), i);
      cyc(0, 0, 0, 1);
    end
    chk("bp_empty", ov[0], 0);

    // Full FIFO with a pop on the same edge as the push.
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(0, 1, i * 32768, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 5 * 32768, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("fp_drop", dc_o[0], 0);
    for (int i = 2; i <= 5; i++) begin
      chk("fp_valid", ov[0], 1);
      chk("fp_data", longint'($signed(od[0])), i);
      cyc(0, 0, 0, 1);
    end
    chk("fp_empty", ov[0], 0);

    // Reset mid-stream.
    do_reset();
    cyc(0, 1, 32768, 0);
    cyc(0, 1, 8388607, 0);
    cyc(0, 1, 65536, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("mr_sat_pre", sc_o[0], 1);
    chk("mr_valid_pre", ov[0], 1);
    do_reset();
    chk("mr_valid", ov[0], 0);
    chk("mr_data", od[0], 0);
    chk("mr_sat", sc_o[0], 0);
    chk("mr_drop", dc_o[0], 0);
    cyc(0, 1, 98304, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("mr_next_valid", ov[0], 1);
    chk("mr_next_data", longint'($signed(od[0])), 3);
    cyc(0, 0, 0, 1);

    // Randomized traffic on both instances.
    do_reset();
    fork
      for (int n = 0; n < 1500; n++) begin
        int v; bit en, r;
        en = $urandom_range(0, 3) != 0;
        r  = $urandom_range(0, 7) < ((n % 200) < 100 ? 7 : 2);
        case ($urandom_range(0, 2))
          0:       v = int'($urandom) >>> 8;
          1:       v = int'($urandom_range(0, 131072)) - 65536;
          default: v = ($urandom_range(0, 1) ? 1 : -1) * (4100000 + int'($urandom_range(0, 200000)));
        endcase
        cyc(0, en, v, r);
      end
      for (int n = 0; n < 1500; n++) begin
        int v; bit en, r;
        en = $urandom_range(0, 1) != 0;
        r  = $urandom_range(0, 7) < ((n % 150) < 75 ? 7 : 1);
        v  = int'($urandom) >>> 8;
        cyc(1, en, v, r);
      end
    join
    repeat (20) begin
      fork
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
      join
    end
    chk("drain_a", sbq[0].size(), 0);
    chk("drain_b", sbq[1].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_output_stage.md
# fir_output_stage

Receive-side end of the transposed FIR tap chain. Takes the 24-bit accumulated sum leaving the last tap and rounds it back to the 8-bit sample domain with saturation. Optionally decimates the result, then buffers it in a small FIFO and presents it downstream with a valid/ready handshake. The tap chain cannot stall, so the block never back-pressures upstream; when the FIFO is full, new results are dropped and counted.

## Interface
Parameters:
- SUM_W, 24: width of signed sum from tap chain
- OUT_W, 8: width of signed output sample
- FRAC_SHIFT, 15: fractional bits of coefficients (Q1.15); right-shift applied after rounding
- DECIM, 1: decimation factor, 1..16; keep one result in DECIM
- FIFO_DEPTH, 4: output FIFO entries, power of two, ≥2

Ports:
- clk, in, 1: clock
- reset, in, 1: synchronous, active-high reset
- sample_en, in, 1: sum_in is valid this cycle (one pulse per input sample)
- sum_in, in, SUM_W: signed sum from last tap
- out_data, out, OUT_W: signed quantized sample at FIFO head
- out_valid, out, 1: FIFO non-empty
- out_ready, in, 1: downstream accepts out_data this cycle
- sat_count, out, 16: number of saturated results, saturating at 0xFFFF
- drop_count, out, 16: number of results lost to full FIFO, saturating at 0xFFFF

## Operation
- Decimation counter `phase` counts 0..DECIM-1 on each sample_en. Only samples arriving at phase 0 enter the pipeline. After reset, the first sample is forwarded.
- Stage 1 (S1) register: captures sum_in and sets v1 when sample_en is high and phase is 0; otherwise v1 is 0.
- Stage 2 (S2), quantize:
  - Compute in SUM_W+1 bits: t = (S1 + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT. This is round half toward +inf.
  - If t > 2^(OUT_W-1)-1, clamp to 127. If t < -2^(OUT_W-1), clamp to -128.
  - Clamping increments sat_count. Result is registered with v2.
- FIFO push occurs when v2 is high. Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the result is discarded and drop_count increments.
- FIFO pop occurs when out_valid and out_ready are both high. The next entry, if any, appears on out_data the following cycle.
- Simultaneous push and pop on an empty FIFO is impossible, because out_valid=0 means no pop. On a full FIFO, both are accepted and occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a separate count (0..FIFO_DEPTH).
- Reset values:
  - out_valid=0, out_data=0, sat_count=0, drop_count=0
  - phase=0, v1=v2=0, FIFO empty
- Reset mid-operation discards all pipeline and FIFO contents.

## Timing
- sum_in is sampled at edge E0. The quantized value is in S2 after E1 and written to the FIFO at E2. With an empty FIFO, out_valid=1 after E2, giving a latency of 3 edges.
- Throughput: one result per cycle, sustainable with out_ready held at 1.
- out_data/out_valid are registered FIFO head outputs, with no combinational path from out_ready.
- out_valid, once high, stays high with out_data stable until the entry is popped; a drop never alters the head.
- sat_count increments at E2, in the same cycle as the push attempt. drop_count increments at the same edge as the rejected push.

## Structure
- Shared package fir_pkg holds SUM_W, OUT_W, COEF_W=16, SAMPLE_W=8 and FRAC_SHIFT as constants, plus typedefs sum_t and sample_t. tap and this block both import it.
- One sub-module, fir_out_fifo: a parameterized synchronous FIFO with push/pop/full/empty/count and registered head.
- Quantizer and decimation counter stay inline.

## Test plan
- Rounding, with DECIM=1 and out_ready=1:
  - sum_in=163840 gives out_data=5.
  - 16384 gives 1.
  - -16384 gives 0.
  - -16385 gives -1.
  - Each result appears 3 cycles after sample_en.
- Saturation: 8388607 gives 127 and -8388608 gives -128. sat_count=2 and drop_count=0.
- Decimation, DECIM=2: sums 32768, 65536, 98304, 131072 on consecutive sample_en give outputs 1 and 3 only.
- Backpressure, FIFO_DEPTH=4 with out_ready=0: send 6 samples of values 1..6. Expect 4 entries; drop_count=2; out_data is 1, 2, 3, 4 in order once out_ready=1; then out_valid=0.
- Full plus simultaneous pop: with FIFO full, assert out_ready=1 on the same cycle a new result arrives. Expect no drop and occupancy to stay at 4.
- Reset mid-stream: with 3 entries queued and sat_count=1, pulse reset for 1 cycle. Expect out_valid=0, counters 0, and the next sample forwarded with phase 0.
